// File: rtl/mutative_dfp_adapter_pkg.sv
// Shared constants and types for the DFP line-to-burst adapter.
// The burst length is derived from the two widths, so a line always splits into whole beats.
package mutative_dfp_adapter_pkg;

  localparam int ADDR_BITS   = 32;
  localparam int LINE_BITS   = 256;
  localparam int BURST_BITS  = 64;
  localparam int BURST_LEN   = LINE_BITS / BURST_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int BEAT_BITS   = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RESP    = 3'd4
  } dfp_adapter_state_t;

  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  function automatic int unsigned beat_lsb(input logic [BEAT_BITS-1:0] b);
    return int'(b) * BURST_BITS;
  endfunction

endpackage

// File: rtl/mutative_dfp_adapter_if.sv
// Line-side (cache DFP) and beat-side (burst memory) buses of the adapter.
//
// Handshakes: dfp_read/dfp_write are level requests held with addr/wdata until the
// single-cycle dfp_resp. On the memory side bmem_read/bmem_write act as valid and
// bmem_ready as ready; a request or write beat transfers on a cycle where both are 1.
// Read beats (bmem_rvalid) carry no backpressure and are always taken.
interface mutative_dfp_line_if;
  import mutative_dfp_adapter_pkg::*;

  logic [ADDR_BITS-1:0] dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;

  modport master (output dfp_addr, dfp_read, dfp_write, dfp_wdata,
                  input  dfp_rdata, dfp_resp);
  modport slave  (input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
                  output dfp_rdata, dfp_resp);
endinterface

interface mutative_bmem_if;
  import mutative_dfp_adapter_pkg::*;

  logic [ADDR_BITS-1:0]  bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BURST_BITS-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [BURST_BITS-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  modport master (output bmem_addr, bmem_read, bmem_write, bmem_wdata,
                  input  bmem_ready, bmem_rdata, bmem_rvalid);
  modport slave  (input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
                  output bmem_ready, bmem_rdata, bmem_rvalid);
endinterface

// File: rtl/mutative_dfp_adapter.sv
// Serialises one 256-bit DFP line read or write into four 64-bit burst-memory beats,
// then pulses dfp_resp. All outputs come straight from flops.
module mutative_dfp_adapter
  import mutative_dfp_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mutative_dfp_line_if.slave dfp,
  mutative_bmem_if.master    bmem,
  output dfp_adapter_state_t dbg_state
);

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_LEN - 1);

  dfp_adapter_state_t    state_q, state_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LINE_BITS-1:0]  line_q, line_d;
  logic                  bmem_read_q, bmem_read_d;
  logic                  bmem_write_q, bmem_write_d;
  logic [BURST_BITS-1:0] bmem_wdata_q, bmem_wdata_d;
  logic                  dfp_resp_q, dfp_resp_d;
  logic [LINE_BITS-1:0]  dfp_rdata_q, dfp_rdata_d;
  logic                  unused_addr_bits;

  // Offset bits within a line never reach memory.
  assign unused_addr_bits = ^dfp.dfp_addr[OFFSET_BITS-1:0];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;

    case (state_q)
      ST_IDLE: begin
        // A write wins a tie; the read stays asserted and is picked up next time round.
        if (dfp.dfp_write) begin
          state_d = ST_WR;
          beat_d  = '0;
          addr_d  = line_align(dfp.dfp_addr);
          line_d  = dfp.dfp_wdata;
        end else if (dfp.dfp_read) begin
          state_d = ST_RD_REQ;
          beat_d  = '0;
          addr_d  = line_align(dfp.dfp_addr);
        end
      end
      ST_WR: begin
        if (bmem.bmem_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_RESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        if (bmem.bmem_ready) begin
          state_d = ST_RD_DATA;
          beat_d  = '0;
        end
      end
      ST_RD_DATA: begin
        if (bmem.bmem_rvalid) begin
          line_d[beat_lsb(beat_q) +: BURST_BITS] = bmem.bmem_rdata;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_RESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    bmem_write_d = (state_d == ST_WR);
    bmem_read_d  = (state_d == ST_RD_REQ);
    bmem_wdata_d = (state_d == ST_WR) ? line_d[beat_lsb(beat_d) +: BURST_BITS] : '0;
    dfp_resp_d   = (state_d == ST_RESP);
    dfp_rdata_d  = (state_q == ST_RD_DATA && state_d == ST_RESP) ? line_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      addr_q       <= '0;
      line_q       <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
      dfp_resp_q   <= 1'b0;
      dfp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_wdata_q <= bmem_wdata_d;
      dfp_resp_q   <= dfp_resp_d;
      dfp_rdata_q  <= dfp_rdata_d;
    end
  end

  assign bmem.bmem_addr  = addr_q;
  assign bmem.bmem_read  = bmem_read_q;
  assign bmem.bmem_write = bmem_write_q;
  assign bmem.bmem_wdata = bmem_wdata_q;
  assign dfp.dfp_resp    = dfp_resp_q;
  assign dfp.dfp_rdata   = dfp_rdata_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mutative_dfp_adapter.sv
// Directed bench for mutative_dfp_adapter: a vector table of single transactions plus
// hand-written sequences for tie-break, back-to-back and mid-burst reset.
module tb_mutative_dfp_adapter;
  import mutative_dfp_adapter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mutative_dfp_line_if dfp_if ();
  mutative_bmem_if     bmem_if ();
  dfp_adapter_state_t  dbg_state;

  mutative_dfp_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .dfp       (dfp_if),
    .bmem      (bmem_if),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic           wr;
    logic           rd;
    logic [31:0]    addr;
    logic [255:0]   line;
  } req_t;

  typedef struct {
    logic           is_write;
    logic [31:0]    addr;
    logic [255:0]   line;
    int             stall;      // ready-low cycles on write beat 2
    int             req_wait;   // ready-low cycles on the read request
    int             rd_lat;     // cycles from request accept to first read beat
    int             gap_beat;   // one idle rvalid cycle before this beat (4 = none)
    logic [31:0]    exp_addr;
    int             exp_resp;   // cycle of dfp_resp, request cycle = 1
  } vec_t;

  // ---------------- scoreboard state ----------------
  int checks, errors, cyc;
  logic [63:0]  exp_q[$];
  logic [255:0] exp_line_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [255:0] mem_line_q[$];
  req_t         req_q[$];
  int           resp_cyc_q[$];
  int stall_left, wr_beats, req_wait_left, rd_lat, gap_beat, rd_t, rd_k, abort_rd_beats;
  logic         rd_active;
  logic [255:0] rd_line;
  localparam int STALL_BEAT = 2;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input int got, input int exp);
    checks++;
    errors++;
    $display("FAIL %s got=%0d exp=%0d", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input req_t r);
    dfp_if.dfp_write = r.wr;
    dfp_if.dfp_read  = r.rd;
    dfp_if.dfp_addr  = r.addr;
    dfp_if.dfp_wdata = r.wr ? r.line : '0;
  endtask

  task automatic drop_req();
    req_t r;
    r.wr = 1'b0; r.rd = 1'b0; r.addr = '0; r.line = '0;
    drive_req(r);
  endtask

  task automatic clear_model();
    exp_q.delete(); exp_line_q.delete(); exp_addr_q.delete();
    mem_line_q.delete(); req_q.delete(); resp_cyc_q.delete();
    stall_left = 0; wr_beats = 0; req_wait_left = 0; rd_lat = 1; gap_beat = 4;
    rd_t = 0; rd_k = 0; rd_active = 1'b0; abort_rd_beats = 0;
  endtask

  task automatic push_write_beats(input logic [255:0] line);
    for (int k = 0; k < 4; k++) exp_q.push_back(line[k*64 +: 64]);
  endtask

  // Acts as burst memory and requester, one negedge per cycle, until n_resp
  // responses plus two quiet cycles, an abort point, or the budget runs out.
  task automatic serve(input int n_resp, input int budget);
    int seen, last;
    seen = 0; last = 0; cyc = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (rd_active) rd_t++;
      if (abort_rd_beats != 0 && rd_k == abort_rd_beats) return;
      chk("rw_exclusive", {bmem_if.bmem_read, bmem_if.bmem_write} == 2'b11, 1'b0);
      bmem_if.bmem_ready  = 1'b0;
      bmem_if.bmem_rvalid = 1'b0;
      bmem_if.bmem_rdata  = '0;
      if (bmem_if.bmem_write) begin
        if (exp_q.size() == 0 || exp_addr_q.size() == 0) fail_now("wr_beat_unexpected", 1, 0);
        else begin
          chk("wr_addr", bmem_if.bmem_addr, exp_addr_q[0]);
          chk("wr_data", bmem_if.bmem_wdata, exp_q[0]);
          if (wr_beats == STALL_BEAT && stall_left > 0) stall_left--;
          else begin
            bmem_if.bmem_ready = 1'b1;
            void'(exp_q.pop_front());
            wr_beats++;
          end
        end
      end
      if (bmem_if.bmem_read) begin
        if (mem_line_q.size() == 0 || exp_addr_q.size() == 0) fail_now("rd_req_unexpected", 1, 0);
        else begin
          chk("rd_addr", bmem_if.bmem_addr, exp_addr_q[0]);
          if (req_wait_left > 0) req_wait_left--;
          else begin
            bmem_if.bmem_ready = 1'b1;
            rd_active = 1'b1; rd_t = 0; rd_k = 0;
            rd_line = mem_line_q.pop_front();
          end
        end
      end
      if (rd_active && rd_k < 4 && rd_t == rd_lat + rd_k + ((rd_k >= gap_beat) ? 1 : 0)) begin
        bmem_if.bmem_rvalid = 1'b1;
        bmem_if.bmem_rdata  = rd_line[rd_k*64 +: 64];
        rd_k++;
        if (rd_k == 4) rd_active = 1'b0;
      end
      if (dfp_if.dfp_resp) begin
        seen++; last = cyc;
        resp_cyc_q.push_back(cyc);
        if (exp_line_q.size() == 0) fail_now("resp_unexpected", seen, n_resp);
        else chk("resp_rdata", dfp_if.dfp_rdata, exp_line_q.pop_front());
        if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
        wr_beats = 0;
        if (req_q.size() > 0) drive_req(req_q.pop_front());
        else drop_req();
      end
      if (seen >= n_resp && cyc >= last + 2) return;
    end
    fail_now("serve_timeout_resps", seen, n_resp);
  endtask

  task automatic load_vec(input vec_t v);
    req_t r;
    clear_model();
    if (v.is_write) begin
      push_write_beats(v.line);
      exp_line_q.push_back('0);
    end else begin
      mem_line_q.push_back(v.line);
      exp_line_q.push_back(v.line);
    end
    exp_addr_q.push_back(v.exp_addr);
    stall_left = v.stall; req_wait_left = v.req_wait;
    rd_lat = v.rd_lat; gap_beat = v.gap_beat;
    r.wr = v.is_write; r.rd = !v.is_write; r.addr = v.addr; r.line = v.line;
    drive_req(r);
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [255:0] l,
                              input int st, input int rw, input int lat, input int gap,
                              input logic [31:0] ea, input int er);
    vec_t v;
    v.is_write = w; v.addr = a; v.line = l; v.stall = st; v.req_wait = rw;
    v.rd_lat = lat; v.gap_beat = gap; v.exp_addr = ea; v.exp_resp = er;
    return v;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_bmem_read"},  bmem_if.bmem_read, 1'b0);
    chk({tag, "_bmem_write"}, bmem_if.bmem_write, 1'b0);
    chk({tag, "_bmem_wdata"}, bmem_if.bmem_wdata, '0);
    chk({tag, "_bmem_addr"},  bmem_if.bmem_addr, '0);
    chk({tag, "_dfp_resp"},   dfp_if.dfp_resp, 1'b0);
    chk({tag, "_dfp_rdata"},  dfp_if.dfp_rdata, '0);
    chk({tag, "_state"},      dbg_state, ST_IDLE);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[5];
  req_t r;
  logic [255:0] l1, l2, l3, l4, l5, l6;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    drop_req();
    bmem_if.bmem_ready = 1'b0; bmem_if.bmem_rvalid = 1'b0; bmem_if.bmem_rdata = '0;
    clear_model();

    vecs[0] = mk(1'b1, 32'h0000_1234, {64'hD, 64'hC, 64'hB, 64'hA}, 0, 0, 1, 4, 32'h0000_1220, 6);
    vecs[1] = mk(1'b0, 32'h8000_0040, {64'd4, 64'd3, 64'd2, 64'd1}, 0, 0, 3, 2, 32'h8000_0040, 10);
    vecs[2] = mk(1'b1, 32'hDEAD_BEEF, {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001}, 5, 0, 1, 4, 32'hDEAD_BEE0, 11);
    vecs[3] = mk(1'b0, 32'h0000_003F, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A,
                 64'h0123_4567_89AB_CDEF}, 0, 0, 1, 4, 32'h0000_0020, 7);
    vecs[4] = mk(1'b0, 32'hFFFF_FFFF, {64'h8, 64'h7, 64'h6, 64'h5}, 0, 2, 1, 4, 32'hFFFF_FFE0, 9);

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");

    for (int i = 0; i < 5; i++) begin
      load_vec(vecs[i]);
      serve(1, 60);
      chk("vec_resp_count", resp_cyc_q.size(), 1);
      if (resp_cyc_q.size() > 0) chk("vec_resp_cycle", resp_cyc_q[0], vecs[i].exp_resp);
      chk("vec_beats_left", exp_q.size(), 0);
    end

    // Read and write raised together: write first, read served after RESP.
    l1 = {64'h1D, 64'h1C, 64'h1B, 64'h1A};
    l2 = {64'h2D, 64'h2C, 64'h2B, 64'h2A};
    clear_model();
    push_write_beats(l1);
    exp_line_q.push_back('0); exp_line_q.push_back(l2);
    exp_addr_q.push_back(32'h0000_4000); exp_addr_q.push_back(32'h0000_4000);
    mem_line_q.push_back(l2);
    r.wr = 1'b0; r.rd = 1'b1; r.addr = 32'h0000_4013; r.line = '0;
    req_q.push_back(r);
    r.wr = 1'b1; r.line = l1;
    drive_req(r);
    serve(2, 80);
    chk("tie_resp_count", resp_cyc_q.size(), 2);
    if (resp_cyc_q.size() == 2) begin
      chk("tie_resp0_cycle", resp_cyc_q[0], 6);
      chk("tie_resp1_cycle", resp_cyc_q[1], 13);
    end

    // Flush-engine style back-to-back writes with new data presented at RESP.
    l3 = {64'h3D, 64'h3C, 64'h3B, 64'h3A};
    l4 = {64'h4D, 64'h4C, 64'h4B, 64'h4A};
    clear_model();
    push_write_beats(l3); push_write_beats(l4);
    exp_line_q.push_back('0); exp_line_q.push_back('0);
    exp_addr_q.push_back(32'h0000_0100); exp_addr_q.push_back(32'h2000_0100);
    r.wr = 1'b1; r.rd = 1'b0; r.addr = 32'h2000_0108; r.line = l4;
    req_q.push_back(r);
    r.addr = 32'h0000_0100; r.line = l3;
    drive_req(r);
    serve(2, 80);
    chk("b2b_resp_count", resp_cyc_q.size(), 2);
    if (resp_cyc_q.size() == 2) begin
      chk("b2b_resp0_cycle", resp_cyc_q[0], 6);
      chk("b2b_resp1_cycle", resp_cyc_q[1], 12);
    end
    chk("b2b_beats_left", exp_q.size(), 0);

    // Reset during RD_DATA after two beats: silent abort, then a clean write.
    l5 = {64'h5D, 64'h5C, 64'h5B, 64'h5A};
    l6 = {64'h6D, 64'h6C, 64'h6B, 64'h6A};
    clear_model();
    mem_line_q.push_back(l5); exp_line_q.push_back(l5);
    exp_addr_q.push_back(32'h0000_0800);
    abort_rd_beats = 2;
    r.wr = 1'b0; r.rd = 1'b1; r.addr = 32'h0000_081F; r.line = '0;
    drive_req(r);
    serve(1, 40);
    chk("abort_state_before_reset", dbg_state, ST_RD_DATA);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    drop_req();
    bmem_if.bmem_ready = 1'b0; bmem_if.bmem_rvalid = 1'b0; bmem_if.bmem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset_no_resp", dfp_if.dfp_resp, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("after_reset_no_resp", dfp_if.dfp_resp, 1'b0);
    load_vec(mk(1'b1, 32'h0000_0060, l6, 0, 0, 1, 4, 32'h0000_0060, 6));
    serve(1, 60);
    chk("post_reset_resp_count", resp_cyc_q.size(), 1);
    if (resp_cyc_q.size() > 0) chk("post_reset_resp_cycle", resp_cyc_q[0], 6);
    chk("post_reset_beats_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
